// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer: ALU opcode/width constants and FSM state encoding.
package mac_seq_pkg;

    localparam int unsigned REG_WORD_LEN = 16;
    localparam int unsigned ALU_MODE_LEN = 4;
    localparam int unsigned SHIFT_LEN    = 4;

    localparam logic [ALU_MODE_LEN-1:0] ALU_NOP = 4'd0;
    localparam logic [ALU_MODE_LEN-1:0] ALU_ADD = 4'd1;
    localparam logic [ALU_MODE_LEN-1:0] ALU_MUL = 4'd3;

    typedef enum logic [2:0] {
        MS_IDLE = 3'd0,
        MS_RD_X = 3'd1,
        MS_RD_H = 3'd2,
        MS_MUL  = 3'd3,
        MS_ADD  = 3'd4,
        MS_DONE = 3'd5
    } ms_state_e;

endpackage

// File: rtl/mac_seq.sv
// Dot-product sequencer: fetches x[i]/h[i] from a single-port RAM and drives a shared
// ALU through MUL then ADD per tap, accumulating into a 16-bit sign-magnitude result.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic [ADDR_W-1:0]       x_base,
    input  logic [ADDR_W-1:0]       h_base,
    output logic                    busy,
    output logic                    done,
    output logic [REG_WORD_LEN-1:0] result,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [REG_WORD_LEN-1:0] rd_data,
    output logic [ALU_MODE_LEN-1:0] alu_opcode,
    output logic [REG_WORD_LEN-1:0] alu_a,
    output logic [REG_WORD_LEN-1:0] alu_b,
    output logic [REG_WORD_LEN-1:0] alu_c,
    output logic [SHIFT_LEN-1:0]    alu_shift,
    input  logic [REG_WORD_LEN-1:0] alu_out
);

    ms_state_e               state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0]       xb_q, xb_d;
    logic [ADDR_W-1:0]       hb_q, hb_d;
    logic [REG_WORD_LEN-1:0] acc_q, acc_d;
    logic [REG_WORD_LEN-1:0] x_q, x_d;
    logic [REG_WORD_LEN-1:0] prod_q, prod_d;
    logic [REG_WORD_LEN-1:0] result_q, result_d;
    logic                    last_tap;

    assign last_tap = (idx_q == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MS_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            xb_q     <= '0;
            hb_q     <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            xb_q     <= xb_d;
            hb_q     <= hb_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: if (start) state_d = (len != '0) ? MS_RD_X : MS_DONE;
            MS_RD_X: state_d = MS_RD_H;
            MS_RD_H: state_d = MS_MUL;
            MS_MUL:  state_d = MS_ADD;
            MS_ADD:  state_d = last_tap ? MS_DONE : MS_RD_X;
            MS_DONE: state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        len_d    = len_q;
        idx_d    = idx_q;
        xb_d     = xb_q;
        hb_d     = hb_q;
        acc_d    = acc_q;
        x_d      = x_q;
        prod_d   = prod_q;
        result_d = result_q;
        case (state_q)
            MS_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len != '0) begin
                        len_d = len;
                        xb_d  = x_base;
                        hb_d  = h_base;
                        idx_d = '0;
                    end
                end
            end
            MS_RD_H: x_d    = rd_data;
            MS_MUL:  prod_d = alu_out;
            MS_ADD: begin
                acc_d = alu_out;
                idx_d = idx_q + LEN_W'(1);
            end
            MS_DONE: result_d = acc_q;
            default: ;
        endcase
    end

    // result bypasses the register during DONE so it lines up with the done pulse
    always_comb begin
        busy       = (state_q != MS_IDLE);
        done       = (state_q == MS_DONE);
        result     = (state_q == MS_DONE) ? acc_q : result_q;
        rd_en      = 1'b0;
        rd_addr    = '0;
        alu_opcode = ALU_NOP;
        alu_a      = '0;
        alu_b      = '0;
        case (state_q)
            MS_RD_X: begin
                rd_en   = 1'b1;
                rd_addr = xb_q + ADDR_W'(idx_q);
            end
            MS_RD_H: begin
                rd_en   = 1'b1;
                rd_addr = hb_q + ADDR_W'(idx_q);
            end
            MS_MUL: begin
                alu_opcode = ALU_MUL;
                alu_a      = x_q;
                alu_b      = rd_data;
            end
            MS_ADD: begin
                alu_opcode = ALU_ADD;
                alu_a      = prod_q;
                alu_b      = acc_q;
            end
            default: ;
        endcase
    end

    assign alu_c     = '0;
    assign alu_shift = '0;

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq with a sign-magnitude Q1.15 ALU model and a 1-cycle RAM.
module tb_mac_seq;
    import mac_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len, x_base, h_base;
    logic        busy, done, rd_en;
    logic [15:0] result, rd_data, alu_a, alu_b, alu_c, alu_out;
    logic [7:0]  rd_addr;
    logic [3:0]  alu_opcode, alu_shift;

    logic [15:0] mem [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    logic [7:0] addr_q [$];
    op_t        op_q [$];

    mac_seq #(.ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .x_base(x_base), .h_base(h_base), .busy(busy), .done(done),
        .result(result), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_shift(alu_shift), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sm_mul(input logic [15:0] a, input logic [15:0] b);
        logic [29:0] p;
        logic [14:0] m;
        p = a[14:0] * b[14:0];
        m = p[29:15];
        return {(m != '0) && (a[15] ^ b[15]), m};
    endfunction

    function automatic logic [15:0] sm_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic        sg;
        if (a[15] == b[15]) begin
            s  = {1'b0, a[14:0]} + {1'b0, b[14:0]};
            if (s > 16'h7FFF) s = 16'h7FFF;
            sg = a[15];
        end else if (a[14:0] >= b[14:0]) begin
            s  = {1'b0, a[14:0]} - {1'b0, b[14:0]};
            sg = a[15];
        end else begin
            s  = {1'b0, b[14:0]} - {1'b0, a[14:0]};
            sg = b[15];
        end
        return {(s[14:0] != '0) && sg, s[14:0]};
    endfunction

    always_comb begin
        case (alu_opcode)
            ALU_MUL: alu_out = sm_mul(alu_a, alu_b);
            ALU_ADD: alu_out = sm_add(alu_a, alu_b);
            default: alu_out = '0;
        endcase
    end

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic ms_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (rd_en) begin
                if (addr_q.size() == 0) ms_check("rd_spurious", {24'h0, rd_addr}, 32'hFFFF_FFFF);
                else ms_check("rd_addr", {24'h0, rd_addr}, {24'h0, addr_q.pop_front()});
            end
            if (alu_opcode != ALU_NOP) begin
                if (op_q.size() == 0) ms_check("alu_spurious", {28'h0, alu_opcode}, 32'hFFFF_FFFF);
                else ms_check("alu_op", {alu_opcode, alu_a, alu_b}, op_q.pop_front());
            end else begin
                ms_check("idle_operands", {alu_a, alu_b}, 32'h0);
            end
            ms_check("alu_c_shift", {alu_c, 12'h0, alu_shift}, 32'h0);
        end
    end

    task automatic run_job(input int n, input logic [7:0] xb, input logic [7:0] hb,
                           input logic [15:0] exp_res, input bit noisy);
        logic [15:0] acc, p, xv, hv;
        logic [7:0]  ax, ah;
        int          k;
        bit          got;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            ax = xb + 8'(i);
            ah = hb + 8'(i);
            xv = mem[ax];
            hv = mem[ah];
            p  = sm_mul(xv, hv);
            addr_q.push_back(ax);
            addr_q.push_back(ah);
            op_q.push_back({ALU_MUL, xv, hv});
            op_q.push_back({ALU_ADD, p, acc});
            acc = sm_add(p, acc);
        end
        @(negedge clk);
        start = 1'b1; len = 8'(n); x_base = xb; h_base = hb;
        @(posedge clk);
        #1 start = 1'b0;
        if (noisy) begin
            len = 8'hFF; x_base = 8'h00; h_base = 8'h00;
        end
        k = 0;
        got = 1'b0;
        while (!got && k < 4 * n + 20) begin
            @(negedge clk);
            k++;
            if (done) begin
                got = 1'b1;
                ms_check("latency", k, 4 * n + 1);
                ms_check("result", {16'h0, result}, {16'h0, exp_res});
                ms_check("busy_in_done", {31'h0, busy}, 32'h1);
            end
            start = noisy && (k < 4 * n - 1) && (k % 3 == 0);
        end
        start = 1'b0;
        if (!got) ms_check("done_timeout", 32'h0, 32'h1);
        @(negedge clk);
        ms_check("result_held", {16'h0, result}, {16'h0, exp_res});
        ms_check("busy_after", {31'h0, busy}, 32'h0);
        ms_check("done_pulse", {31'h0, done}, 32'h0);
        repeat (3) @(negedge clk);
        ms_check("no_extra_done", {30'h0, busy, done}, 32'h0);
        ms_check("addr_q_empty", addr_q.size(), 0);
        ms_check("op_q_empty", op_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; len = '0; x_base = '0; h_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ms_check("rst_ctrl", {28'h0, busy, done, rd_en, 1'b0}, 32'h0);
        ms_check("rst_result", {16'h0, result}, 32'h0);
        ms_check("rst_alu", {alu_opcode, 4'h0, alu_a[7:0], rd_addr, alu_b[7:0]}, {ALU_NOP, 28'h0});
        rst = 1'b0;
        mon_en = 1'b1;

        mem[8'h20] = 16'h4000; mem[8'h30] = 16'h4000;
        run_job(1, 8'h20, 8'h30, 16'h2000, 1'b0);

        mem[8'h40] = 16'h4000; mem[8'h41] = 16'h2000;
        mem[8'h50] = 16'h4000; mem[8'h51] = 16'h4000;
        run_job(2, 8'h40, 8'h50, 16'h3000, 1'b0);

        run_job(0, 8'h40, 8'h50, 16'h0000, 1'b0);

        mem[8'h60] = 16'h4000; mem[8'h61] = 16'hC000;
        mem[8'h70] = 16'h4000; mem[8'h71] = 16'h4000;
        run_job(2, 8'h60, 8'h70, 16'h0000, 1'b0);

        mem[8'hB0] = 16'h7000; mem[8'hB1] = 16'h7000;
        mem[8'hC0] = 16'h7FFF; mem[8'hC1] = 16'h7FFF;
        run_job(2, 8'hB0, 8'hC0, 16'h7FFF, 1'b0);

        mem[8'hFF] = 16'h1000; mem[8'h00] = 16'h1000;
        mem[8'h80] = 16'h4000; mem[8'h81] = 16'h4000;
        run_job(2, 8'hFF, 8'h80, 16'h1000, 1'b1);

        for (int i = 0; i < 3; i++) begin
            mem[8'h90 + 8'(i)] = 16'h4000;
            mem[8'hA0 + 8'(i)] = 16'h2000;
        end
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1; len = 8'd3; x_base = 8'h90; h_base = 8'hA0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        ms_check("mul_tap1", {28'h0, alu_opcode}, {28'h0, ALU_MUL});
        rst = 1'b1;
        @(negedge clk);
        ms_check("abort_busy_done", {30'h0, busy, done}, 32'h0);
        ms_check("abort_alu", {28'h0, alu_opcode}, {28'h0, ALU_NOP});
        ms_check("abort_result", {16'h0, result}, 32'h0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            ms_check("abort_no_done", {30'h0, busy, done}, 32'h0);
        end
        mon_en = 1'b1;
        run_job(3, 8'h90, 8'hA0, 16'h3000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
